// File: rtl/fifo_ctrl.sv
// fifo_ctrl: read/write pointer and flag controller that runs an external
// dual-port RAM as a synchronous FIFO. The RAM read is registered, so
// rdValid is the accepted pop delayed by one cycle. Occupancy and flags are
// decoded only from the registered pointers.
module fifo_ctrl #(
  parameter int MEM_DEPTH = 8,
  parameter int AF_LEVEL  = 6,
  parameter int AE_LEVEL  = 2,
  localparam int AW       = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          wrReq,
  input  logic          rdReq,
  input  logic          clrErr,
  output logic          ramWrEn,
  output logic          ramRdEn,
  output logic [AW-1:0] ramWrAddr,
  output logic [AW-1:0] ramRdAddr,
  output logic          rdValid,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          almostFull,
  output logic          almostEmpty,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] AF_CNT  = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_CNT  = (AW+1)'(AE_LEVEL);

  // The pointers carry one extra wrap bit so that full and empty can be
  // told apart when the address fields match.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        push_ok;
  logic        pop_ok;

  assign count       = wr_ptr - rd_ptr;
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty       = (wr_ptr == rd_ptr);
  assign almostFull  = (count >= AF_CNT);
  assign almostEmpty = (count <= AE_CNT);

  assign push_ok   = wrReq & ~full;
  assign pop_ok    = rdReq & ~empty;
  assign ramWrEn   = push_ok;
  assign ramRdEn   = pop_ok;
  assign ramWrAddr = wr_ptr[AW-1:0];
  assign ramRdAddr = rd_ptr[AW-1:0];

  // Move the pointers on accepted operations. The address field and the wrap
  // bit roll over naturally.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // RAM read data is valid on the cycle after an accepted pop.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) rdValid <= 1'b0;
    else       rdValid <= pop_ok;
  end

  // Sticky error flags. A new error in the same cycle as clrErr takes
  // priority over the clear.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wrReq && full)       overflow  <= 1'b1;
      else if (clrErr)         overflow  <= 1'b0;
      if (rdReq && empty)      underflow <= 1'b1;
      else if (clrErr)         underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl with an 8-entry behavioural RAM.
module tb_fifo_ctrl;

  logic       clk;
  logic       rstN;
  logic       wrReq, rdReq, clrErr;
  logic       ramWrEn, ramRdEn;
  logic [2:0] ramWrAddr, ramRdAddr;
  logic       rdValid;
  logic [3:0] count;
  logic       full, empty, almostFull, almostEmpty, overflow, underflow;

  logic [7:0] wdata;
  logic [7:0] rd_data;
  logic [7:0] mem [8];

  fifo_ctrl #(.MEM_DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .rstN(rstN), .wrReq(wrReq), .rdReq(rdReq), .clrErr(clrErr),
    .ramWrEn(ramWrEn), .ramRdEn(ramRdEn), .ramWrAddr(ramWrAddr), .ramRdAddr(ramRdAddr),
    .rdValid(rdValid), .count(count), .full(full), .empty(empty),
    .almostFull(almostFull), .almostEmpty(almostEmpty),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dual-port RAM with registered read (never reset).
  always @(posedge clk) begin
    if (ramWrEn) mem[ramWrAddr] <= wdata;
    if (ramRdEn) rd_data <= mem[ramRdAddr];
  end

  // Status vector: count, full, empty, af, ae, ovf, udf, wren, rden, wa, ra, rv
  typedef struct {
    string       nm;
    logic [18:0] v;
    bit          flush;
    bit          drain;
  } exp_t;

  exp_t       st_q[$];
  logic [7:0] exp_data[$];
  logic [7:0] ref_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor: compares status snapshots and popped data on the falling edge.
  always @(negedge clk) begin
    logic [18:0] act;
    exp_t        e;
    logic [7:0]  d;
    act = {count, full, empty, almostFull, almostEmpty, overflow, underflow,
           ramWrEn, ramRdEn, ramWrAddr, ramRdAddr, rdValid};
    while (st_q.size() > 0) begin
      e = st_q.pop_front();
      n_checks++;
      if (e.drain) begin
        if (exp_data.size() == 0) n_pass++;
        else $display("FAIL drain: %0d popped words never presented, want 0", exp_data.size());
      end else begin
        if (e.flush) exp_data.delete();
        if (act === e.v) n_pass++;
        else $display("FAIL %s: got %b want %b (cnt,f,e,af,ae,ovf,udf,we,re,wa,ra,rv)",
                      e.nm, act, e.v);
      end
    end
    if (rdValid === 1'b1) begin
      n_checks++;
      if (exp_data.size() == 0) begin
        $display("FAIL rd_data: rdValid with no pending pop, got %0d", rd_data);
      end else begin
        d = exp_data.pop_front();
        if (rd_data === d) n_pass++;
        else $display("FAIL rd_data: got %0d want %0d", rd_data, d);
      end
    end
  end

  // Expected-state model of the FIFO seen from its ports.
  int         m_cnt = 0;
  logic [2:0] m_wa = '0, m_ra = '0;
  logic       m_rv = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
  int         next_data = 1;

  task automatic step(input logic r, input logic wr, input logic rd,
                      input logic clr, input string nm);
    logic push_ok, pop_ok, full_now, empty_now;
    exp_t e;
    @(posedge clk); #1;
    rstN = r; wrReq = wr; rdReq = rd; clrErr = clr; wdata = 8'(next_data);
    if (!r) begin
      m_cnt = 0; m_wa = '0; m_ra = '0; m_rv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      ref_q.delete();
    end
    full_now  = (m_cnt == 8);
    empty_now = (m_cnt == 0);
    push_ok   = wr && !full_now;
    pop_ok    = rd && !empty_now;
    e.nm = nm; e.flush = !r; e.drain = 1'b0;
    e.v = {4'(m_cnt), full_now, empty_now, (m_cnt >= 6), (m_cnt <= 2), m_ovf, m_udf,
           push_ok, pop_ok, m_wa, m_ra, m_rv};
    st_q.push_back(e);
    if (r) begin
      if (push_ok) begin
        ref_q.push_back(8'(next_data));
        next_data++;
        m_wa = m_wa + 3'd1;
        m_cnt++;
      end
      if (pop_ok) begin
        exp_data.push_back(ref_q.pop_front());
        m_ra = m_ra + 3'd1;
        m_cnt--;
      end
      m_rv = pop_ok;
      if (wr && full_now)      m_ovf = 1'b1;
      else if (clr)            m_ovf = 1'b0;
      if (rd && empty_now)     m_udf = 1'b1;
      else if (clr)            m_udf = 1'b0;
    end
  endtask

  task automatic repeat_step(input int n, input logic wr, input logic rd, input string nm);
    for (int i = 0; i < n; i++) step(1'b1, wr, rd, 1'b0, nm);
  endtask

  initial begin
    exp_t e;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rstN = 1'b0; wrReq = 1'b0; rdReq = 1'b0; clrErr = 1'b0; wdata = '0;
    step(1'b0, 0, 0, 0, "reset");
    step(1'b1, 0, 0, 0, "idle_after_reset");
    // Fill, then overflow.
    repeat_step(8, 1, 0, "fill");
    step(1'b1, 1, 0, 0, "push_when_full");
    step(1'b1, 0, 0, 0, "overflow_set");
    // Drain in order, then underflow, then clear.
    repeat_step(8, 0, 1, "drain");
    step(1'b1, 0, 1, 0, "pop_when_empty");
    step(1'b1, 0, 0, 1, "clr_err");
    step(1'b1, 0, 0, 0, "errors_cleared");
    // Address wrap from a fresh reset.
    step(1'b0, 0, 0, 0, "reset_wrap");
    repeat_step(5, 1, 0, "wrap_push_a");
    repeat_step(5, 0, 1, "wrap_pop_a");
    repeat_step(5, 1, 0, "wrap_push_b");
    repeat_step(5, 0, 1, "wrap_pop_b");
    repeat_step(4, 1, 0, "wrap_push_c");
    step(1'b1, 0, 0, 0, "wrap_count4");
    // Streaming at count 3.
    step(1'b1, 0, 1, 0, "to_count3");
    repeat_step(20, 1, 1, "stream");
    step(1'b1, 0, 0, 0, "stream_end");
    // Push+pop while full.
    repeat_step(5, 1, 0, "refill");
    step(1'b1, 1, 1, 0, "pushpop_full");
    step(1'b1, 0, 0, 0, "after_pushpop_full");
    // Push+pop while empty.
    repeat_step(7, 0, 1, "to_empty");
    step(1'b1, 1, 1, 0, "pushpop_empty");
    step(1'b1, 0, 0, 1, "after_pushpop_empty");
    step(1'b1, 0, 0, 0, "cleared_again");
    // Asynchronous reset mid-burst at count 5.
    repeat_step(4, 1, 0, "to_count5");
    step(1'b1, 1, 1, 0, "burst_count5");
    step(1'b0, 0, 0, 0, "async_reset");
    repeat_step(3, 1, 0, "resume_push");
    repeat_step(3, 0, 1, "resume_pop");
    step(1'b1, 0, 0, 0, "resume_idle");
    // Every popped word must have been presented by now.
    @(posedge clk); #1;
    wrReq = 1'b0; rdReq = 1'b0; clrErr = 1'b0;
    e.nm = "drain"; e.v = '0; e.flush = 1'b0; e.drain = 1'b1;
    st_q.push_back(e);
    @(posedge clk); @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
